// File: rtl/uart_baud_pkg.sv
// Shared UART baud constants, divisor typedefs and the clock/baud -> divisor helper.
package uart_baud_pkg;

  localparam int     OVERSAMPLE_DEF    = 16;
  localparam int     DIV_INT_BITS_DEF  = 16;
  localparam int     DIV_FRAC_BITS_DEF = 4;
  localparam longint CLOCK_RATE        = 100_000_000;
  localparam longint BAUD_RATE         = 9600;

  typedef logic [DIV_INT_BITS_DEF-1:0]  div_int_t;
  typedef logic [DIV_FRAC_BITS_DEF-1:0] div_frac_t;

  // Fixed-point divisor (int part << frac_bits | frac part), rounded to nearest.
  function automatic longint calc_div_fx(input longint clk_hz, input longint baud,
                                         input int os, input int frac_bits);
    longint den;
    den = baud * longint'(os);
    return ((clk_hz << frac_bits) + den / 2) / den;
  endfunction

  localparam longint DEF_DIV_FX   = calc_div_fx(CLOCK_RATE, BAUD_RATE, OVERSAMPLE_DEF,
                                                DIV_FRAC_BITS_DEF);
  localparam int     DEF_DIV_INT  = int'(DEF_DIV_FX >> DIV_FRAC_BITS_DEF);
  localparam int     DEF_DIV_FRAC = int'(DEF_DIV_FX & ((64'd1 << DIV_FRAC_BITS_DEF) - 1));

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional divisor accumulator: holds the active fraction, acc and the carry that
// stretches the following oversample period by one cycle.
module baud_frac_accum
  import uart_baud_pkg::*;
#(
  parameter int FRAC_BITS  = DIV_FRAC_BITS_DEF,
  parameter int RESET_FRAC = DEF_DIV_FRAC
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_apply,
  input  logic [FRAC_BITS-1:0] i_frac_new,
  output logic                 o_carry
);

  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic                 carry_q, carry_d;

  always_comb begin
    frac_d  = frac_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    // A divisor change restarts the fraction so the new rate begins phase-clean.
    if (i_apply) begin
      frac_d  = i_frac_new;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (i_tick) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      frac_q  <= FRAC_BITS'(RESET_FRAC);
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign o_carry = carry_q;

endmodule

// File: rtl/baud_tick_generator_prog.sv
// Programmable fractional baud tick generator (oversample / bit / mid-bit ticks).
// Fractional divisor support is built only when BAUD_FRAC_DIV_EN is defined.
module baud_tick_generator_prog
  import uart_baud_pkg::*;
#(
  parameter int DIV_INT_BITS   = DIV_INT_BITS_DEF,
  parameter int DIV_FRAC_BITS  = DIV_FRAC_BITS_DEF,
  parameter int OVERSAMPLE     = OVERSAMPLE_DEF,
  parameter int RESET_DIV_INT  = DEF_DIV_INT,
  parameter int RESET_DIV_FRAC = DEF_DIV_FRAC
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [DIV_INT_BITS-1:0]  i_div_int,
  input  logic [DIV_FRAC_BITS-1:0] i_div_frac,
  input  logic                     i_div_load,
  output logic                     o_os_tick,
  output logic                     o_bit_tick,
  output logic                     o_mid_tick,
  output logic                     o_div_pending,
  output logic [DIV_INT_BITS-1:0]  o_div_active
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  logic [DIV_INT_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_INT_BITS-1:0] active_int_q, active_int_d;
  logic [DIV_INT_BITS-1:0] shadow_int_q, shadow_int_d;
  logic [OS_W-1:0]         os_cnt_q, os_cnt_d;
  logic                    pending_q, pending_d;

  logic [DIV_INT_BITS-1:0] eff_int, period_m1, new_int;
  logic                    os_tick, apply, carry;

  // Zero divisor runs as divide-by-one; carry stretches the period by one cycle.
  assign eff_int   = (active_int_q == '0) ? DIV_INT_BITS'(1) : active_int_q;
  assign period_m1 = eff_int - DIV_INT_BITS'(1) + DIV_INT_BITS'(carry);
  assign os_tick   = i_enable && (cnt_q == period_m1);
  assign new_int   = i_div_load ? i_div_int : shadow_int_q;

  always_comb begin
    cnt_d        = cnt_q;
    os_cnt_d     = os_cnt_q;
    pending_d    = pending_q;
    active_int_d = active_int_q;
    shadow_int_d = i_div_load ? i_div_int : shadow_int_q;
    apply        = 1'b0;
    if (!i_enable) begin
      // Idle load: take effect now and restart phase-aligned.
      if (i_div_load) begin
        apply     = 1'b1;
        cnt_d     = '0;
        os_cnt_d  = '0;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d = os_tick ? '0 : cnt_q + DIV_INT_BITS'(1);
      if (os_tick) os_cnt_d = os_cnt_q + OS_W'(1);
      // Running load: only swap at a period boundary; a coincident load wins directly.
      if (os_tick && (i_div_load || pending_q)) begin
        apply     = 1'b1;
        pending_d = 1'b0;
      end else if (i_div_load) begin
        pending_d = 1'b1;
      end
    end
    if (apply) active_int_d = new_int;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q        <= '0;
      os_cnt_q     <= '0;
      pending_q    <= 1'b0;
      active_int_q <= DIV_INT_BITS'(RESET_DIV_INT);
      shadow_int_q <= DIV_INT_BITS'(RESET_DIV_INT);
    end else begin
      cnt_q        <= cnt_d;
      os_cnt_q     <= os_cnt_d;
      pending_q    <= pending_d;
      active_int_q <= active_int_d;
      shadow_int_q <= shadow_int_d;
    end
  end

`ifdef BAUD_FRAC_DIV_EN
  logic [DIV_FRAC_BITS-1:0] shadow_frac_q, shadow_frac_d, new_frac;

  assign shadow_frac_d = i_div_load ? i_div_frac : shadow_frac_q;
  assign new_frac      = i_div_load ? i_div_frac : shadow_frac_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) shadow_frac_q <= DIV_FRAC_BITS'(RESET_DIV_FRAC);
    else         shadow_frac_q <= shadow_frac_d;
  end

  baud_frac_accum #(
    .FRAC_BITS  (DIV_FRAC_BITS),
    .RESET_FRAC (RESET_DIV_FRAC)
  ) u_frac (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_tick     (os_tick),
    .i_apply    (apply),
    .i_frac_new (new_frac),
    .o_carry    (carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^{i_div_frac, RESET_DIV_FRAC[0]};
  assign carry       = 1'b0;
`endif

  assign o_os_tick     = os_tick;
  assign o_bit_tick    = os_tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign o_mid_tick    = os_tick && (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
  assign o_div_pending = pending_q;
  assign o_div_active  = active_int_q;

endmodule

// File: doc/baud_tick_generator_prog.md
Name: baud_tick_generator_prog

Overview:
Runtime-programmable baud tick generator for the UART tx and rx paths.
- Divides i_clock by a fractional divisor (integer part + DIV_FRAC_BITS-bit fraction) to produce an oversample tick.
- Derives a bit tick and a mid-bit tick from the oversample tick.
- A new divisor is loaded glitch-free: it is applied only at a period boundary, or immediately while disabled.

Parameters:
DIV_INT_BITS, 16, width of integer divisor part
DIV_FRAC_BITS, 4, width of fractional divisor part (units of 1/2^DIV_FRAC_BITS cycle)
OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4
RESET_DIV_INT, 651, integer divisor after reset (100 MHz / (9600*16))
RESET_DIV_FRAC, 1, fractional divisor after reset

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  run enable; low freezes generation
i_div_int  in  DIV_INT_BITS  requested integer divisor
i_div_frac  in  DIV_FRAC_BITS  requested fractional divisor
i_div_load  in  1  one-cycle strobe capturing i_div_int/i_div_frac into shadow
o_os_tick  out  1  one-cycle oversample tick
o_bit_tick  out  1  one-cycle tick every OVERSAMPLE os ticks
o_mid_tick  out  1  one-cycle tick at the mid-point of each bit
o_div_pending  out  1  shadow divisor loaded, not yet applied
o_div_active  out  DIV_INT_BITS  integer divisor currently in force

Behaviour:
- Clock is i_clock; reset is i_reset, synchronous, active-high.
- Reset values:
  - cycle counter = 0, frac accumulator = 0, os counter = 0, carry = 0.
  - Active divisor = RESET_DIV_INT/RESET_DIV_FRAC.
  - Shadow divisor = reset values; pending = 0.
  - All tick outputs = 0; o_div_active = RESET_DIV_INT.
- Effective integer divisor: eff_int = max(active_int, 1). A value of 0 behaves as 1.
- Period length: P = eff_int + carry, where carry is registered at the previous os tick. P is 1 .. 2^DIV_INT_BITS.
- Cycle counter:
  - Counts enabled cycles 0..P-1.
  - o_os_tick = (counter == P-1) && i_enable; counter returns to 0 on the same edge.
  - The first tick after reset occurs on the P-th enabled cycle (P = RESET_DIV_INT).
- Fraction:
  - On each os tick, {carry, acc} <= acc + active_frac, computed at DIV_FRAC_BITS+1 width.
  - carry lengthens the next period by one cycle.
- OS counter:
  - Increments on each os tick and wraps from OVERSAMPLE-1 to 0.
  - o_bit_tick = o_os_tick && os_cnt == OVERSAMPLE-1.
  - o_mid_tick = o_os_tick && os_cnt == OVERSAMPLE/2-1.
  - All ticks are combinational decodes of registered state, so there is zero added latency.
- Divisor load while enabled:
  - i_div_load writes the shadow and sets pending.
  - At the next os tick, the shadow becomes active, acc and carry clear, pending clears, and the os counter is not disturbed.
  - If the load coincides with an os tick, the new value is applied at that tick and governs the period starting next cycle; pending stays 0.
  - A load while pending overwrites the shadow; the last load wins.
- Divisor load while disabled: the shadow is applied on the next edge. Counter, acc, carry and os counter clear, so the next run starts phase-aligned.
- Enable low: counter, acc and os counter hold; all ticks are 0. Re-enabling resumes mid-period with no lost or extra cycle.
- Reset mid-period: all state returns to reset values on that edge; a pending load is discarded.

Optional Feature:
BAUD_FRAC_DIV_EN
- Defined: fractional accumulator as described.
- Undefined: accumulator and carry are removed; i_div_frac and RESET_DIV_FRAC are ignored; P = eff_int always. All other behaviour is identical.

Decomposition:
- Package uart_baud_pkg holds:
  - OVERSAMPLE default.
  - Default CLOCK_RATE/BAUD_RATE constants.
  - A constant function computing the integer and fractional divisor from clock and baud.
  - Divisor width typedefs.
- One sub-module, baud_frac_accum, holds acc, carry and the apply/clear controls. It is instantiated only under BAUD_FRAC_DIV_EN.

Test Plan:
- Reset, enable=1, OVERSAMPLE=16; load div_int=4, frac=0 while disabled, then enable -> os tick every 4 cycles; bit tick every 64 cycles coincident with os tick; mid tick 32 cycles earlier.
- div_int=4, frac=8 (FRAC_BITS=4) -> os periods 4,4,5,4,5,...; 9 cycles per 2 ticks long-run. With the macro off -> constant 4.
- Running at div_int=10; load div_int=3 at cycle 2 of a period -> o_div_pending=1 until the current 10-cycle period ends, then the 3-cycle period starts; os counter continuous.
- Load coinciding with an os tick, plus two back-to-back loads (5 then 7) -> the coincident load applies at once; for the back-to-back pair, 7 is applied at the next tick.
- div_int=0 -> os tick every cycle; i_enable low for 5 cycles mid-period -> no ticks, counter holds, tick spacing resumes exactly.
- Assert i_reset with a load pending -> outputs 0, o_div_active=651, pending=0; first tick 651 cycles after release.
